qft_phase_sched: RTL

QFT_PHASE_SCHED -- requirements
Module: qft_phase_sched

---
 rtl/qft_phase_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/qft_phase_sched.sv
// rtl/qft_phase_sched.sv - 8-point QFT phase-rotation scheduler with stallable issue/result pipeline
// Loads N samples, then streams each through an external complex multiplier with twiddle table[(k*j) mod N].
module qft_phase_sched #(
    parameter int N_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         k,
    output logic               busy,
    output logic               done,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [7:0]  s_in_r,
    input  logic signed [7:0]  s_in_i,
    output logic signed [7:0]  mul_in_r,
    output logic signed [7:0]  mul_in_i,
    output logic signed [11:0] mul_cos,
    output logic signed [11:0] mul_sin,
    input  logic signed [12:0] mul_out_r,
    input  logic signed [12:0] mul_out_i,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [12:0] m_out_r,
    output logic signed [12:0] m_out_i,
    output logic [2:0]         m_idx
);

    localparam int N  = 1 << N_LOG2;
    localparam int JW = N_LOG2 + 1;
    localparam logic [JW-1:0] N_J      = JW'(N);
    localparam logic [JW-1:0] LAST_J   = JW'(N - 1);
    localparam logic [2:0]    LAST_IDX = 3'(N - 1);

    localparam logic signed [11:0] P1 = 12'sd1024;
    localparam logic signed [11:0] M1 = -12'sd1024;
    localparam logic signed [11:0] PH = 12'sd724;
    localparam logic signed [11:0] MH = -12'sd724;
    localparam logic signed [11:0] Z0 = 12'sd0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROT, S_DONE} state_t;

    state_t state_q, state_d;
    logic [JW-1:0]      j_q, j_d;
    logic [2:0]         k_q, k_d;
    logic               op_valid_q, op_valid_d;
    logic [2:0]         op_idx_q, op_idx_d;
    logic signed [7:0]  mul_in_r_q, mul_in_r_d, mul_in_i_q, mul_in_i_d;
    logic signed [11:0] mul_cos_q, mul_cos_d, mul_sin_q, mul_sin_d;
    logic               m_valid_q, m_valid_d;
    logic signed [12:0] m_out_r_q, m_out_r_d, m_out_i_q, m_out_i_d;
    logic [2:0]         m_idx_q, m_idx_d;

    logic signed [7:0]  samp_r_q [N];
    logic signed [7:0]  samp_i_q [N];
    logic               wr_en;
    logic               adv;
    logic [2:0]         tw_idx;
    logic [23:0]        tw;

    function automatic logic [23:0] twiddle(input logic [2:0] idx);
        case (idx)
            3'd0:    twiddle = {P1, Z0};
            3'd1:    twiddle = {PH, PH};
            3'd2:    twiddle = {Z0, P1};
            3'd3:    twiddle = {MH, PH};
            3'd4:    twiddle = {M1, Z0};
            3'd5:    twiddle = {MH, MH};
            3'd6:    twiddle = {Z0, M1};
            default: twiddle = {PH, MH};
        endcase
    endfunction

    // 3-bit product wraps naturally, giving (k*j) mod 8
    assign tw_idx = k_q * j_q[2:0];
    assign tw     = twiddle(tw_idx);
    assign adv    = !m_valid_q || m_ready;

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        k_d        = k_q;
        op_valid_d = op_valid_q;
        op_idx_d   = op_idx_q;
        mul_in_r_d = mul_in_r_q;
        mul_in_i_d = mul_in_i_q;
        mul_cos_d  = mul_cos_q;
        mul_sin_d  = mul_sin_q;
        m_valid_d  = m_valid_q;
        m_out_r_d  = m_out_r_q;
        m_out_i_d  = m_out_i_q;
        m_idx_d    = m_idx_q;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k;
                    j_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (j_q == LAST_J) begin
                        j_d     = '0;
                        state_d = S_ROT;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            S_ROT: begin
                if (adv) begin
                    if (j_q < N_J) begin
                        mul_in_r_d = samp_r_q[j_q[N_LOG2-1:0]];
                        mul_in_i_d = samp_i_q[j_q[N_LOG2-1:0]];
                        mul_cos_d  = tw[23:12];
                        mul_sin_d  = tw[11:0];
                        op_valid_d = 1'b1;
                        op_idx_d   = j_q[2:0];
                        j_d        = j_q + 1'b1;
                    end else begin
                        op_valid_d = 1'b0;
                    end
                end
                if (m_valid_q && m_ready && (m_idx_q == LAST_IDX)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result register: captures the combinational multiplier product of the held operand
        if (adv) begin
            if (op_valid_q) begin
                m_valid_d = 1'b1;
                m_out_r_d = mul_out_r;
                m_out_i_d = mul_out_i;
                m_idx_d   = op_idx_q;
            end else begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            k_q        <= '0;
            op_valid_q <= 1'b0;
            op_idx_q   <= '0;
            mul_in_r_q <= '0;
            mul_in_i_q <= '0;
            mul_cos_q  <= '0;
            mul_sin_q  <= '0;
            m_valid_q  <= 1'b0;
            m_out_r_q  <= '0;
            m_out_i_q  <= '0;
            m_idx_q    <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            k_q        <= k_d;
            op_valid_q <= op_valid_d;
            op_idx_q   <= op_idx_d;
            mul_in_r_q <= mul_in_r_d;
            mul_in_i_q <= mul_in_i_d;
            mul_cos_q  <= mul_cos_d;
            mul_sin_q  <= mul_sin_d;
            m_valid_q  <= m_valid_d;
            m_out_r_q  <= m_out_r_d;
            m_out_i_q  <= m_out_i_d;
            m_idx_q    <= m_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            samp_r_q[j_q[N_LOG2-1:0]] <= s_in_r;
            samp_i_q[j_q[N_LOG2-1:0]] <= s_in_i;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign s_ready  = (state_q == S_LOAD);
    assign mul_in_r = mul_in_r_q;
    assign mul_in_i = mul_in_i_q;
    assign mul_cos  = mul_cos_q;
    assign mul_sin  = mul_sin_q;
    assign m_valid  = m_valid_q;
    assign m_out_r  = m_out_r_q;
    assign m_out_i  = m_out_i_q;
    assign m_idx    = m_idx_q;

endmodule
